dbi_decoder: RTL
================

DBI_DECODER -- requirements
Module: dbi_decoder

Interface
REQ-001 The block SHALL take parameter DEPTH, default 2, as the output buffer depth in words (power of two, 2..8).
REQ-002 The block SHALL take parameter CNT_W, default 16, as the width of the statistics counters.
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  upstream word valid.
REQ-006 in_ready  output  1  block can accept a word this cycle.
REQ-007 in_data  input  8  word as transmitted by the DBI encoder.
REQ-008 in_dbi  input  1  inversion flag sent with in_data (1 = in_data is the complement of the original word).
REQ-009 out_valid  output  1  restored word available.
REQ-010 out_ready  input  1  downstream accepts the word.
REQ-011 out_data  output  8  restored original word.
REQ-012 stat_clr  input  1  synchronous clear of the counters and the sticky error flag.
REQ-013 inv_cnt  output  CNT_W  count of accepted words with in_dbi=1.
REQ-014 err_cnt  output  CNT_W  count of accepted words that violate the encoding rule.
REQ-015 err  output  1  sticky flag, set on the first violation.

Function
REQ-016 A word SHALL be accepted in a cycle where in_valid=1 and in_ready=1.
REQ-017 The restored word SHALL be ~in_data when in_dbi=1, else in_data, and SHALL be written into the buffer at acceptance.
REQ-018 The buffer SHALL be a DEPTH-entry FIFO with wrapping read/write pointers and an occupancy count of width log2(DEPTH)+1.
REQ-019 in_ready SHALL be 1 exactly when occupancy < DEPTH; it SHALL be registered-state-derived and have no combinational path from out_ready.
REQ-020 out_valid SHALL be 1 exactly when occupancy > 0; out_data SHALL be the head entry.
REQ-021 A word accepted in cycle N SHALL first appear on out_valid/out_data in cycle N+1; there is no same-cycle bypass.
REQ-022 A pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged and preserve order.
REQ-024 Pointers SHALL wrap from DEPTH-1 to 0 with no lost or duplicated word.
REQ-025 Encoding rule: the encoder never transmits more than four 1s. An accepted word where popcount(in_data) > 4 SHALL be a violation, regardless of in_dbi.
REQ-026 A violating word SHALL still be decoded and buffered normally.
REQ-027 On each accepted word, inv_cnt SHALL increment if in_dbi=1; err_cnt SHALL increment and err SHALL set if the word violates the rule.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-029 stat_clr=1 SHALL zero inv_cnt, err_cnt and err on the next edge. When stat_clr=1 coincides with an acceptance, the clear SHALL win for that cycle.
REQ-030 stat_clr SHALL NOT affect the buffer contents or the handshake.

Reset
REQ-031 While rst=1, the block SHALL asynchronously set occupancy and both pointers to 0, giving out_valid=0 and in_ready=1.
REQ-032 While rst=1, the block SHALL asynchronously set inv_cnt=0, err_cnt=0, err=0 and out_data=8'h00.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered words. The first acceptance after deassertion SHALL behave as from empty.
REQ-034 Buffer storage entries need no reset; out_data SHALL read 0 whenever out_valid=0 after reset until the first write.

Structure
REQ-035 Constants (data width 8, popcount threshold 4) and the default DEPTH/CNT_W SHALL live in a shared package, dbi_pkg.
REQ-036 The FIFO SHALL be a sub-module named sync_fifo (clk, rst, push, pop, wdata, rdata, full, empty).
REQ-037 Decode, popcount check and counters SHALL reside in dbi_decoder.

Verification
REQ-038 Decode: in_data=8'h0F, in_dbi=1, out_ready=1 -> next cycle out_valid=1, out_data=8'hF0, inv_cnt=1, err=0.
REQ-039 Backpressure: with out_ready=0, push 8'h01, 8'h02 (dbi=0) -> in_ready=0 after the 2nd; raise out_ready -> out_data 8'h01 then 8'h02, each for one cycle.
REQ-040 Violation: in_data=8'h1F (5 ones), in_dbi=0 -> out_data=8'h1F, err=1, err_cnt=1.
REQ-041 Saturation: CNT_W=4, 20 accepted words with in_dbi=1 -> inv_cnt holds at 15.
REQ-042 Clear priority: stat_clr=1 in the same cycle as a violating acceptance -> err=0, err_cnt=0 next cycle; the word still appears on out_data.
REQ-043 Reset mid-flight: buffer holding 2 words, assert rst -> immediately out_valid=0, in_ready=1, counters 0; after release, push 8'hAA -> out_data=8'hAA next cycle.

Source files
------------

// File: rtl/dbi_pkg.sv
// Shared constants and the popcount helper for the DBI receive path.
package dbi_pkg;

  localparam int          DATA_W    = 8;
  localparam logic [3:0]  POP_MAX   = 4'd4;   // encoder never sends more 1s than this
  localparam int          DEPTH_DEF = 2;
  localparam int          CNT_W_DEF = 16;

  function automatic logic [3:0] popcount8(input logic [DATA_W-1:0] d);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < DATA_W; i++) c = c + {3'b000, d[i]};
    return c;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers wrap naturally since DEPTH is a power of two.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_en, pop_en;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;
  // Drive zero while empty so stale or never-written storage never leaks out.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dbi_decoder.sv
// DBI receive decoder: undoes data-bus inversion, flags words that break the
// popcount rule and buffers the restored words behind a ready/valid FIFO.
module dbi_decoder
  import dbi_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_dbi,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  inv_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err
);

  logic              full, empty, accept, viol;
  logic [DATA_W-1:0] dec_data;

  // in_ready depends only on FIFO occupancy, never on out_ready.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign accept    = in_valid & in_ready;
  assign dec_data  = in_dbi ? ~in_data : in_data;
  assign viol      = (popcount8(in_data) > POP_MAX);

  sync_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (out_valid & out_ready),
    .wdata (dec_data),
    .rdata (out_data),
    .full  (full),
    .empty (empty)
  );

  // Clear beats a coincident acceptance; counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inv_cnt <= '0;
      err_cnt <= '0;
      err     <= 1'b0;
    end else if (stat_clr) begin
      inv_cnt <= '0;
      err_cnt <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      if (in_dbi && inv_cnt != '1) inv_cnt <= inv_cnt + CNT_W'(1);
      if (viol) begin
        err <= 1'b1;
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

endmodule
